data_port_arbiter: RTL and testbench

Shares the single data port of the unified instruction/data memory between two requesters: the CPU load/store stage and the display/boot-load DMA engine. It arbitrates fairly, with a bounded DMA burst lock. It latches the winning request and drives registered port signals into the memory. It range-checks the address against the selected space (main memory or display buffer) and returns read data with a one-cycle Done pulse. The block sits between the pipeline MEM stage and the memory's DataAdd/MemDataContent/DataWriteEn/DataReadEn/MEMTYPE inputs; the instruction port is untouched.

---
 rtl/data_port_arbiter_pkg.sv | 34 +++
 rtl/data_port_arbiter_if.sv | 48 ++++
 rtl/rr_lock_arbiter2.sv | 39 +++
 rtl/data_port_arbiter.sv | 137 +++++++++++++
 tb/tb_data_port_arbiter.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/data_port_arbiter_pkg.sv
// +--------------------------------------------------------------------------+
// | data_port_arbiter_pkg : shared encodings and range check for the arbiter |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package data_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic {
        GNT_CPU = 1'b0,
        GNT_DMA = 1'b1
    } gnt_t;

    localparam int c_MAX_BURST_DEF  = 4;
    localparam int c_MEM_WORDS_DEF  = 1024;
    localparam int c_DISP_BYTES_DEF = 32;

    // Main memory is word addressed and must be aligned; display memory is byte addressed.
    function automatic logic range_err(input logic [31:0] add, input logic mem_type,
                                       input int mem_words, input int disp_bytes);
        if (mem_type)
            return (add >= $unsigned(disp_bytes));
        return (add[1:0] != 2'b00) || ({2'b00, add[31:2]} >= $unsigned(mem_words));
    endfunction

endpackage

`default_nettype wire

// File: rtl/data_port_arbiter_if.sv
// +--------------------------------------------------------------------------+
// | data_port_arbiter_if : requester handshakes plus memory data-port wiring |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

interface data_port_arbiter_if;
    logic        CpuReq;
    logic        CpuWe;
    logic [31:0] CpuAdd;
    logic [31:0] CpuWData;
    logic        CpuMemType;
    logic        DmaReq;
    logic        DmaWe;
    logic [31:0] DmaAdd;
    logic [31:0] DmaWData;
    logic        DmaMemType;
    logic        DmaLock;
    logic        CpuDone;
    logic        DmaDone;
    logic        CpuErr;
    logic        DmaErr;
    logic [31:0] RData;
    logic [31:0] DataAdd;
    logic [31:0] MemDataContent;
    logic        DataWriteEn;
    logic        DataReadEn;
    logic        MEMTYPE;
    logic [31:0] MemDataOut;

    modport slave (
        input  CpuReq, CpuWe, CpuAdd, CpuWData, CpuMemType,
        input  DmaReq, DmaWe, DmaAdd, DmaWData, DmaMemType, DmaLock,
        input  MemDataOut,
        output CpuDone, DmaDone, CpuErr, DmaErr, RData,
        output DataAdd, MemDataContent, DataWriteEn, DataReadEn, MEMTYPE
    );

    modport master (
        output CpuReq, CpuWe, CpuAdd, CpuWData, CpuMemType,
        output DmaReq, DmaWe, DmaAdd, DmaWData, DmaMemType, DmaLock,
        output MemDataOut,
        input  CpuDone, DmaDone, CpuErr, DmaErr, RData,
        input  DataAdd, MemDataContent, DataWriteEn, DataReadEn, MEMTYPE
    );
endinterface

`default_nettype wire

// File: rtl/rr_lock_arbiter2.sv
// +--------------------------------------------------------------------------+
// | rr_lock_arbiter2 : two-way round-robin winner select with DMA burst lock |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module rr_lock_arbiter2
    import data_port_arbiter_pkg::*;
#(
    parameter int MAX_BURST = 4,
    parameter int BW        = 3
) (
    input  wire logic          i_cpu_req,
    input  wire logic          i_dma_req,
    input  wire logic          i_dma_lock,
    input  wire gnt_t          i_last_gnt,
    input  wire logic [BW-1:0] i_burst_cnt,
    output logic               o_valid,
    output gnt_t               o_winner
);

    logic w_lock_win;

    assign w_lock_win = i_dma_lock && i_dma_req && (i_burst_cnt < BW'(MAX_BURST));

    always_comb begin
        o_valid  = i_cpu_req | i_dma_req;
        o_winner = GNT_CPU;
        if (w_lock_win)
            o_winner = GNT_DMA;
        else if (i_cpu_req && i_dma_req)
            o_winner = (i_last_gnt == GNT_DMA) ? GNT_CPU : GNT_DMA;
        else if (i_dma_req)
            o_winner = GNT_DMA;
    end

endmodule

`default_nettype wire

// File: rtl/data_port_arbiter.sv
// +--------------------------------------------------------------------------+
// | data_port_arbiter : shares the unified memory data port, CPU vs DMA      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module data_port_arbiter
    import data_port_arbiter_pkg::*;
#(
    parameter int MEM_WORDS  = c_MEM_WORDS_DEF,
    parameter int DISP_BYTES = c_DISP_BYTES_DEF,
    parameter int MAX_BURST  = c_MAX_BURST_DEF
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    data_port_arbiter_if.slave bus
);

    localparam int c_BW = $clog2(MAX_BURST + 1);

    state_t          r_state;
    gnt_t            r_last_gnt;
    gnt_t            r_owner;
    logic [c_BW-1:0] r_burst_cnt;
    logic            r_err;
    logic            r_cpu_done, r_dma_done, r_cpu_err, r_dma_err;
    logic [31:0]     r_rdata, r_data_add, r_wdata;
    logic            r_we_en, r_re_en, r_mem_type;

    logic            w_valid;
    gnt_t            w_winner;
    logic            w_we, w_mt, w_err;
    logic [31:0]     w_add, w_wdata;

    rr_lock_arbiter2 #(
        .MAX_BURST (MAX_BURST),
        .BW        (c_BW)
    ) u_arb (
        .i_cpu_req   (bus.CpuReq),
        .i_dma_req   (bus.DmaReq),
        .i_dma_lock  (bus.DmaLock),
        .i_last_gnt  (r_last_gnt),
        .i_burst_cnt (r_burst_cnt),
        .o_valid     (w_valid),
        .o_winner    (w_winner)
    );

    always_comb begin
        w_we    = bus.CpuWe;
        w_add   = bus.CpuAdd;
        w_wdata = bus.CpuWData;
        w_mt    = bus.CpuMemType;
        if (w_winner == GNT_DMA) begin
            w_we    = bus.DmaWe;
            w_add   = bus.DmaAdd;
            w_wdata = bus.DmaWData;
            w_mt    = bus.DmaMemType;
        end
    end

    assign w_err = range_err(w_add, w_mt, MEM_WORDS, DISP_BYTES);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_last_gnt  <= GNT_DMA;
            r_owner     <= GNT_CPU;
            r_burst_cnt <= '0;
            r_err       <= 1'b0;
            r_cpu_done  <= 1'b0;
            r_dma_done  <= 1'b0;
            r_cpu_err   <= 1'b0;
            r_dma_err   <= 1'b0;
            r_rdata     <= '0;
            r_data_add  <= '0;
            r_wdata     <= '0;
            r_we_en     <= 1'b0;
            r_re_en     <= 1'b0;
            r_mem_type  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!bus.DmaLock)
                        r_burst_cnt <= '0;
                    if (w_valid) begin
                        r_owner    <= w_winner;
                        r_last_gnt <= w_winner;
                        r_err      <= w_err;
                        r_data_add <= w_add;
                        r_wdata    <= w_wdata;
                        r_mem_type <= w_mt;
                        r_we_en    <= w_we & ~w_err;
                        r_re_en    <= ~w_we & ~w_err;
                        // Only a DMA win taken with the lock held while the CPU waits counts toward the burst.
                        if (w_winner == GNT_CPU)
                            r_burst_cnt <= '0;
                        else if (bus.DmaLock && bus.CpuReq && (r_burst_cnt < c_BW'(MAX_BURST)))
                            r_burst_cnt <= r_burst_cnt + 1'b1;
                        r_state    <= ACCESS;
                    end
                end
                ACCESS: begin
                    r_rdata    <= r_err ? 32'd0 : bus.MemDataOut;
                    r_we_en    <= 1'b0;
                    r_re_en    <= 1'b0;
                    r_cpu_done <= (r_owner == GNT_CPU);
                    r_dma_done <= (r_owner == GNT_DMA);
                    r_cpu_err  <= (r_owner == GNT_CPU) && r_err;
                    r_dma_err  <= (r_owner == GNT_DMA) && r_err;
                    r_state    <= RESP;
                end
                RESP: begin
                    r_cpu_done <= 1'b0;
                    r_dma_done <= 1'b0;
                    r_cpu_err  <= 1'b0;
                    r_dma_err  <= 1'b0;
                    r_state    <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.CpuDone        = r_cpu_done;
    assign bus.DmaDone        = r_dma_done;
    assign bus.CpuErr         = r_cpu_err;
    assign bus.DmaErr         = r_dma_err;
    assign bus.RData          = r_rdata;
    assign bus.DataAdd        = r_data_add;
    assign bus.MemDataContent = r_wdata;
    assign bus.DataWriteEn    = r_we_en;
    assign bus.DataReadEn     = r_re_en;
    assign bus.MEMTYPE        = r_mem_type;

endmodule

`default_nettype wire

// File: tb/tb_data_port_arbiter.sv
// +--------------------------------------------------------------------------+
// | tb_data_port_arbiter : scoreboard bench for the data-port arbiter        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_data_port_arbiter;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    data_port_arbiter_if bus();

    data_port_arbiter #(
        .MEM_WORDS  (1024),
        .DISP_BYTES (32),
        .MAX_BURST  (4)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Memory model: synchronous write, combinational read.
    logic [31:0] mem  [0:1023];
    logic [31:0] disp [0:31];
    always @(posedge clk) begin
        if (bus.DataWriteEn) begin
            if (bus.MEMTYPE) disp[bus.DataAdd[4:0]] <= bus.MemDataContent;
            else             mem[bus.DataAdd[11:2]] <= bus.MemDataContent;
        end
    end
    always_comb bus.MemDataOut = bus.MEMTYPE ? disp[bus.DataAdd[4:0]] : mem[bus.DataAdd[11:2]];

    typedef struct {
        logic        who;
        logic        we;
        logic        re;
        logic [31:0] add;
        logic [31:0] wd;
        logic        mt;
        logic        err;
        logic        chk_rd;
        logic [31:0] rd;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    function automatic void exp_push(input logic who, input logic we, input logic re,
                                     input logic [31:0] add, input logic [31:0] wd,
                                     input logic mt, input logic err,
                                     input logic chk_rd, input logic [31:0] rd);
        exp_t e;
        e.who = who; e.we = we; e.re = re; e.add = add; e.wd = wd;
        e.mt = mt; e.err = err; e.chk_rd = chk_rd; e.rd = rd;
        q.push_back(e);
    endfunction

    // Monitor: port snapshot from the previous negedge is the ACCESS cycle when Done shows.
    logic        s_we, s_re, s_mt;
    logic [31:0] s_add, s_wd;
    exp_t        m_e;
    initial begin
        s_we = 0; s_re = 0; s_mt = 0; s_add = 0; s_wd = 0;
        forever begin
            @(negedge clk);
            if (bus.CpuDone || bus.DmaDone) begin
                if (q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_done: actual cpu=%0b dma=%0b required none",
                             bus.CpuDone, bus.DmaDone);
                end else begin
                    m_e = q.pop_front();
                    chk("done_sel", {30'd0, bus.CpuDone, bus.DmaDone}, m_e.who ? 32'd1 : 32'd2);
                    chk("err_sel", {30'd0, bus.CpuErr, bus.DmaErr},
                        m_e.err ? (m_e.who ? 32'd1 : 32'd2) : 32'd0);
                    if (m_e.chk_rd) chk("rdata", bus.RData, m_e.rd);
                    chk("port_we", {31'd0, s_we}, {31'd0, m_e.we});
                    chk("port_re", {31'd0, s_re}, {31'd0, m_e.re});
                    chk("port_memtype", {31'd0, s_mt}, {31'd0, m_e.mt});
                    if (!m_e.err) chk("port_add", s_add, m_e.add);
                    if (m_e.we)   chk("port_wdata", s_wd, m_e.wd);
                end
            end
            s_we = bus.DataWriteEn; s_re = bus.DataReadEn; s_mt = bus.MEMTYPE;
            s_add = bus.DataAdd; s_wd = bus.MemDataContent;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic cpu_req(input logic we, input logic [31:0] add, input logic [31:0] wd,
                           input logic mt, input int exp_lat);
        int lat = 0;
        bus.CpuWe = we; bus.CpuAdd = add; bus.CpuWData = wd; bus.CpuMemType = mt;
        bus.CpuReq = 1'b1;
        do begin @(posedge clk); #1; lat++; end while (!bus.CpuDone && lat < 40);
        bus.CpuReq = 1'b0;
        if (!bus.CpuDone) begin
            n_chk++; n_fail++;
            $display("FAIL cpu_timeout: actual no CpuDone in %0d cycles required CpuDone", lat);
        end else if (exp_lat > 0) chk("cpu_latency", lat, exp_lat);
    endtask

    task automatic dma_req(input logic we, input logic [31:0] add, input logic [31:0] wd,
                           input logic mt, input int exp_lat);
        int lat = 0;
        bus.DmaWe = we; bus.DmaAdd = add; bus.DmaWData = wd; bus.DmaMemType = mt;
        bus.DmaReq = 1'b1;
        do begin @(posedge clk); #1; lat++; end while (!bus.DmaDone && lat < 40);
        bus.DmaReq = 1'b0;
        if (!bus.DmaDone) begin
            n_chk++; n_fail++;
            $display("FAIL dma_timeout: actual no DmaDone in %0d cycles required DmaDone", lat);
        end else if (exp_lat > 0) chk("dma_latency", lat, exp_lat);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_done"}, {30'd0, bus.CpuDone, bus.DmaDone}, 32'd0);
        chk({tag, "_err"}, {30'd0, bus.CpuErr, bus.DmaErr}, 32'd0);
        chk({tag, "_rdata"}, bus.RData, 32'd0);
        chk({tag, "_dataadd"}, bus.DataAdd, 32'd0);
        chk({tag, "_memdata"}, bus.MemDataContent, 32'd0);
        chk({tag, "_en"}, {30'd0, bus.DataWriteEn, bus.DataReadEn}, 32'd0);
        chk({tag, "_memtype"}, {31'd0, bus.MEMTYPE}, 32'd0);
    endtask

    initial begin
        bus.CpuReq = 0; bus.CpuWe = 0; bus.CpuAdd = 0; bus.CpuWData = 0; bus.CpuMemType = 0;
        bus.DmaReq = 0; bus.DmaWe = 0; bus.DmaAdd = 0; bus.DmaWData = 0; bus.DmaMemType = 0;
        bus.DmaLock = 0;
        rst_n = 0;
        idle(3);
        chk_reset_outputs("reset");
        rst_n = 1;

        // Solo CPU write then read-back
        exp_push(0, 1, 0, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0);
        cpu_req(1, 32'h10, 32'hDEADBEEF, 0, 2);
        idle(1);
        exp_push(0, 1, 0, 32'h14, 32'hCAFEF00D, 0, 0, 0, 0);
        cpu_req(1, 32'h14, 32'hCAFEF00D, 0, 2);
        idle(1);
        exp_push(0, 0, 1, 32'h10, 0, 0, 0, 1, 32'hDEADBEEF);
        cpu_req(0, 32'h10, 0, 0, 2);
        idle(1);

        // Tie at reset exit: CPU, DMA, CPU, DMA
        rst_n = 0; idle(2); rst_n = 1;
        exp_push(0, 0, 1, 32'h10, 0, 0, 0, 1, 32'hDEADBEEF);
        exp_push(1, 0, 1, 32'h14, 0, 0, 0, 1, 32'hCAFEF00D);
        exp_push(0, 0, 1, 32'h14, 0, 0, 0, 1, 32'hCAFEF00D);
        exp_push(1, 0, 1, 32'h10, 0, 0, 0, 1, 32'hDEADBEEF);
        fork
            begin cpu_req(0, 32'h10, 0, 0, 2); cpu_req(0, 32'h14, 0, 0, 0); end
            begin dma_req(0, 32'h14, 0, 0, 5); dma_req(0, 32'h10, 0, 0, 0); end
        join
        idle(1);

        // Lock burst: four DMA, one CPU, then DMA again
        bus.DmaLock = 1;
        for (int i = 0; i < 4; i++) exp_push(1, 0, 1, 32'h10, 0, 0, 0, 1, 32'hDEADBEEF);
        exp_push(0, 0, 1, 32'h14, 0, 0, 0, 1, 32'hCAFEF00D);
        exp_push(1, 0, 1, 32'h10, 0, 0, 0, 1, 32'hDEADBEEF);
        fork
            begin repeat (5) dma_req(0, 32'h10, 0, 0, 0); end
            begin cpu_req(0, 32'h14, 0, 0, 0); end
        join
        bus.DmaLock = 0;
        idle(1);

        // Range checks and the last valid main-memory word
        exp_push(0, 0, 0, 32'h1002, 0, 0, 1, 1, 32'd0);
        cpu_req(0, 32'h1002, 0, 0, 2);
        idle(1);
        exp_push(0, 0, 0, 32'h1000, 32'h11111111, 0, 1, 1, 32'd0);
        cpu_req(1, 32'h1000, 32'h11111111, 0, 2);
        idle(1);
        exp_push(0, 1, 0, 32'hFFC, 32'h0BADF00D, 0, 0, 0, 0);
        cpu_req(1, 32'hFFC, 32'h0BADF00D, 0, 2);
        idle(1);
        exp_push(0, 0, 1, 32'hFFC, 0, 0, 0, 1, 32'h0BADF00D);
        cpu_req(0, 32'hFFC, 0, 0, 2);
        idle(1);
        exp_push(1, 0, 0, 32'd32, 0, 1, 1, 1, 32'd0);
        dma_req(0, 32'd32, 0, 1, 2);
        idle(1);

        // Display memory write and read-back at the top byte
        exp_push(1, 1, 0, 32'd31, 32'hA5, 1, 0, 0, 0);
        dma_req(1, 32'd31, 32'hA5, 1, 2);
        idle(1);
        exp_push(1, 0, 1, 32'd31, 0, 1, 0, 1, 32'hA5);
        dma_req(0, 32'd31, 0, 1, 2);
        idle(1);

        // Reset during the ACCESS cycle of a write
        bus.CpuWe = 1; bus.CpuAdd = 32'h20; bus.CpuWData = 32'h12345678; bus.CpuMemType = 0;
        bus.CpuReq = 1;
        idle(1);
        chk("rst_access_we", {31'd0, bus.DataWriteEn}, 32'd1);
        rst_n = 0;
        bus.CpuReq = 0;
        idle(1);
        chk_reset_outputs("rst_access");
        idle(2);
        rst_n = 1;
        exp_push(0, 0, 1, 32'h10, 0, 0, 0, 1, 32'hDEADBEEF);
        cpu_req(0, 32'h10, 0, 0, 2);

        for (int i = 0; i < 20 && q.size() != 0; i++) idle(1);
        idle(3);
        chk("scoreboard_empty", q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
